// File: rtl/sw_host_driver.sv
// Host-side sequencer for the Smith-Waterman accelerator: takes host commands,
// streams the T sequence into the accelerator, serves S chunks on request and
// returns the final score. Any stream underrun or zero-length command parks the
// block in ERROR until the host issues CLEAR.
module sw_host_driver #(
  parameter int PE_SIZE     = 64,
  parameter int PE_SIZE_LOG = 6,
  parameter int VEF_BIT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd_op,
  input  logic [15:0]            i_t_len,
  input  logic [15:0]            i_s_len,
  output logic                   o_cmd_ready,
  input  logic [17:0]            i_t_word,
  input  logic                   i_t_word_valid,
  output logic                   o_t_word_ready,
  input  logic [2*PE_SIZE-1:0]   i_s_chunk,
  input  logic                   i_s_chunk_valid,
  output logic                   o_s_chunk_ready,
  output logic                   o_set_t,
  output logic                   o_start_cal,
  output logic [17:0]            o_t,
  output logic [2*PE_SIZE-1:0]   o_s,
  output logic [PE_SIZE_LOG:0]   o_s_valid,
  input  logic                   i_request_s,
  input  logic                   i_busy,
  input  logic [VEF_BIT-1:0]     i_result,
  input  logic                   i_valid,
  output logic                   o_done,
  output logic [VEF_BIT-1:0]     o_score,
  output logic                   o_error
);

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_LOAD_T = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;

  // Four-bit encoding leaves unused codes so a corrupted state is detectable.
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_T_ARM  = 4'd1;
  localparam logic [3:0] S_T_LEN  = 4'd2;
  localparam logic [3:0] S_T_DATA = 4'd3;
  localparam logic [3:0] S_T_WAIT = 4'd4;
  localparam logic [3:0] S_CALC   = 4'd5;
  localparam logic [3:0] S_DRAIN  = 4'd6;
  localparam logic [3:0] S_ERROR  = 4'd7;

  logic [3:0]           state;
  logic [15:0]          t_len_q;
  logic [15:0]          t_rem;
  logic [15:0]          s_rem;
  logic [1:0]           wait_cnt;
  logic [2*PE_SIZE-1:0] s_buf;
  logic                 s_buf_full;

  logic                 s_take;
  logic                 s_from_buf;
  logic                 s_bypass;
  logic                 s_underrun;
  logic                 s_chunk_acc;
  logic [15:0]          s_take_n;

  // Bases delivered by one S request: the remainder, capped at one PE row.
  function automatic logic [15:0] chunk_take(input logic [15:0] rem);
    if (rem > 16'(PE_SIZE)) return 16'(PE_SIZE);
    return rem;
  endfunction

  // Nine bases leave per T word; the counter bottoms out at zero.
  function automatic logic [15:0] t_rem_next(input logic [15:0] rem);
    if (rem > 16'd9) return rem - 16'd9;
    return 16'd0;
  endfunction

  // S request decode: a score result pre-empts a request in the same cycle.
  always_comb begin
    s_take          = (state == S_CALC) && i_request_s && !i_valid && (s_rem != 16'd0);
    s_from_buf      = s_take && s_buf_full;
    s_bypass        = s_take && !s_buf_full && i_s_chunk_valid;
    s_underrun      = s_take && !s_buf_full && !i_s_chunk_valid;
    o_s_chunk_ready = (state == S_CALC) && (!s_buf_full || s_from_buf);
    s_chunk_acc     = o_s_chunk_ready && i_s_chunk_valid;
    s_take_n        = chunk_take(s_rem);
  end

  // Host and T-stream handshakes are decoded straight from the state.
  always_comb begin
    o_cmd_ready    = (state == S_IDLE);
    o_t_word_ready = (state == S_T_DATA);
    o_set_t        = (state == S_T_ARM) && i_t_word_valid;
    o_t            = '0;
    if (state == S_T_LEN)
      o_t = {2'b00, t_len_q};
    else if ((state == S_T_DATA) && i_t_word_valid)
      o_t = i_t_word;
  end

  // Sequencer, counters, S buffer and registered accelerator/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      t_len_q     <= '0;
      t_rem       <= '0;
      s_rem       <= '0;
      wait_cnt    <= '0;
      s_buf       <= '0;
      s_buf_full  <= 1'b0;
      o_start_cal <= 1'b0;
      o_done      <= 1'b0;
      o_s         <= '0;
      o_s_valid   <= '0;
      o_score     <= '0;
      o_error     <= 1'b0;
    end else begin
      o_start_cal <= 1'b0;
      o_done      <= 1'b0;
      o_s         <= '0;
      o_s_valid   <= '0;
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            case (i_cmd_op)
              OP_LOAD_T: begin
                if (i_t_len != 16'd0) begin
                  t_len_q <= i_t_len;
                  state   <= S_T_ARM;
                end else begin
                  o_error <= 1'b1;
                  state   <= S_ERROR;
                end
              end
              OP_RUN: begin
                if (i_s_len != 16'd0) begin
                  s_rem       <= i_s_len;
                  s_buf_full  <= 1'b0;
                  o_start_cal <= 1'b1;
                  state       <= S_CALC;
                end else begin
                  o_error <= 1'b1;
                  state   <= S_ERROR;
                end
              end
              default: ;
            endcase
          end
        end
        S_T_ARM: begin
          if (i_t_word_valid) state <= S_T_LEN;
        end
        S_T_LEN: begin
          t_rem <= t_len_q;
          state <= S_T_DATA;
        end
        S_T_DATA: begin
          if (!i_t_word_valid) begin
            o_error <= 1'b1;
            state   <= S_ERROR;
          end else begin
            t_rem <= t_rem_next(t_rem);
            if (t_rem <= 16'd9) begin
              wait_cnt <= '0;
              state    <= S_T_WAIT;
            end
          end
        end
        S_T_WAIT, S_DRAIN: begin
          if (wait_cnt == 2'd3) begin
            if (!i_busy) state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_CALC: begin
          if (i_valid) begin
            o_score  <= i_result;
            o_done   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_DRAIN;
          end else if (s_underrun) begin
            o_error <= 1'b1;
            state   <= S_ERROR;
          end
          if (s_from_buf || s_bypass) begin
            o_s       <= s_from_buf ? s_buf : i_s_chunk;
            o_s_valid <= s_take_n[PE_SIZE_LOG:0];
            s_rem     <= s_rem - s_take_n;
          end
          if (s_from_buf) begin
            s_buf_full <= s_chunk_acc;
            if (s_chunk_acc) s_buf <= i_s_chunk;
          end else if (s_chunk_acc && !s_bypass) begin
            s_buf_full <= 1'b1;
            s_buf      <= i_s_chunk;
          end
        end
        S_ERROR: begin
          if (i_cmd_valid && (i_cmd_op == OP_CLEAR)) begin
            o_error <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_host_driver.sv
// Bench for sw_host_driver: directed scenarios with literal expectations, then
// a long randomized run, all outputs compared every cycle against a
// transaction-level model of the host driver.
module tb_sw_host_driver;

  localparam int PE = 64;
  localparam int PL = 6;
  localparam int VB = 16;

  logic            clk;
  logic            rst_n;
  logic            i_cmd_valid;
  logic [1:0]      i_cmd_op;
  logic [15:0]     i_t_len;
  logic [15:0]     i_s_len;
  logic            o_cmd_ready;
  logic [17:0]     i_t_word;
  logic            i_t_word_valid;
  logic            o_t_word_ready;
  logic [2*PE-1:0] i_s_chunk;
  logic            i_s_chunk_valid;
  logic            o_s_chunk_ready;
  logic            o_set_t;
  logic            o_start_cal;
  logic [17:0]     o_t;
  logic [2*PE-1:0] o_s;
  logic [PL:0]     o_s_valid;
  logic            i_request_s;
  logic            i_busy;
  logic [VB-1:0]   i_result;
  logic            i_valid;
  logic            o_done;
  logic [VB-1:0]   o_score;
  logic            o_error;

  sw_host_driver #(.PE_SIZE(PE), .PE_SIZE_LOG(PL), .VEF_BIT(VB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op), .i_t_len(i_t_len),
    .i_s_len(i_s_len), .o_cmd_ready(o_cmd_ready),
    .i_t_word(i_t_word), .i_t_word_valid(i_t_word_valid), .o_t_word_ready(o_t_word_ready),
    .i_s_chunk(i_s_chunk), .i_s_chunk_valid(i_s_chunk_valid), .o_s_chunk_ready(o_s_chunk_ready),
    .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_t(o_t), .o_s(o_s), .o_s_valid(o_s_valid),
    .i_request_s(i_request_s), .i_busy(i_busy), .i_result(i_result), .i_valid(i_valid),
    .o_done(o_done), .o_score(o_score), .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int hs_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase of the host transaction the driver is in.
  localparam int P_IDLE = 0, P_ARM = 1, P_LEN = 2, P_DATA = 3, P_WAIT = 4,
                 P_CALC = 5, P_ERR = 6;
  int              ph;
  int unsigned     m_tlen, m_trem, m_srem, m_wait;
  bit              m_bfull;
  logic [2*PE-1:0] m_buf;
  bit              e_start, e_done, e_err;
  logic [2*PE-1:0] e_s;
  int unsigned     e_sv;
  logic [VB-1:0]   e_score;

  function automatic bit exp_sready();
    return (ph == P_CALC) && (!m_bfull || (i_request_s && !i_valid && m_srem != 0 && m_bfull));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= P_IDLE; m_tlen <= 0; m_trem <= 0; m_srem <= 0; m_wait <= 0;
      m_bfull <= 1'b0; m_buf <= '0;
      e_start <= 1'b0; e_done <= 1'b0; e_err <= 1'b0; e_s <= '0; e_sv <= 0; e_score <= '0;
    end else begin
      e_start <= 1'b0; e_done <= 1'b0; e_s <= '0; e_sv <= 0;
      case (ph)
        P_IDLE: if (i_cmd_valid) begin
          if (i_cmd_op == 2'b01) begin
            if (i_t_len == 0) begin ph <= P_ERR; e_err <= 1'b1; end
            else begin ph <= P_ARM; m_tlen <= i_t_len; end
          end else if (i_cmd_op == 2'b10) begin
            if (i_s_len == 0) begin ph <= P_ERR; e_err <= 1'b1; end
            else begin ph <= P_CALC; m_srem <= i_s_len; m_bfull <= 1'b0; e_start <= 1'b1; end
          end
        end
        P_ARM: if (i_t_word_valid) ph <= P_LEN;
        P_LEN: begin ph <= P_DATA; m_trem <= m_tlen; end
        P_DATA: begin
          if (!i_t_word_valid) begin ph <= P_ERR; e_err <= 1'b1; end
          else if (m_trem <= 9) begin ph <= P_WAIT; m_wait <= 0; m_trem <= 0; end
          else m_trem <= m_trem - 9;
        end
        P_WAIT: begin
          if (m_wait >= 3 && !i_busy) ph <= P_IDLE;
          m_wait <= m_wait + 1;
        end
        P_CALC: begin
          int unsigned n;
          bit acc, from_buf, bypass;
          n        = (m_srem < PE) ? m_srem : PE;
          acc      = exp_sready() && i_s_chunk_valid;
          from_buf = i_request_s && !i_valid && m_srem != 0 && m_bfull;
          bypass   = i_request_s && !i_valid && m_srem != 0 && !m_bfull && i_s_chunk_valid;
          if (i_valid) begin
            e_score <= i_result; e_done <= 1'b1; ph <= P_WAIT; m_wait <= 0;
          end else if (i_request_s && m_srem != 0) begin
            if (from_buf) begin e_s <= m_buf; e_sv <= n; m_srem <= m_srem - n; end
            else if (bypass) begin e_s <= i_s_chunk; e_sv <= n; m_srem <= m_srem - n; end
            else begin ph <= P_ERR; e_err <= 1'b1; end
          end
          if (from_buf) begin
            m_bfull <= acc;
            if (acc) m_buf <= i_s_chunk;
          end else if (acc && !bypass) begin
            m_bfull <= 1'b1; m_buf <= i_s_chunk;
          end
        end
        P_ERR: if (i_cmd_valid && i_cmd_op == 2'b00) begin ph <= P_IDLE; e_err <= 1'b0; end
        default: ph <= P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", o_cmd_ready, ph == P_IDLE);
      chk("t_word_ready", o_t_word_ready, ph == P_DATA);
      chk("set_t", o_set_t, (ph == P_ARM) && i_t_word_valid);
      chk("t", o_t, (ph == P_LEN) ? 18'(m_tlen) :
                    ((ph == P_DATA) && i_t_word_valid) ? i_t_word : 18'd0);
      chk("s_chunk_ready", o_s_chunk_ready, exp_sready());
      chk("start_cal", o_start_cal, e_start);
      chk("s", o_s, e_s);
      chk("s_valid", o_s_valid, 7'(e_sv));
      chk("done", o_done, e_done);
      chk("score", o_score, e_score);
      chk("error", o_error, e_err);
    end
  end

  // Chunk handshakes seen on the S stream.
  always @(negedge clk) if (i_s_chunk_valid && o_s_chunk_ready) hs_cnt <= hs_cnt + 1;

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    i_cmd_valid = 0; i_cmd_op = 0; i_t_len = 0; i_s_len = 0;
    i_t_word = 0; i_t_word_valid = 0; i_s_chunk = '0; i_s_chunk_valid = 0;
    i_request_s = 0; i_busy = 0; i_result = 0; i_valid = 0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] tl, input logic [15:0] sl);
    i_cmd_valid = 1; i_cmd_op = op; i_t_len = tl; i_s_len = sl;
    cyc();
    i_cmd_valid = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (!o_cmd_ready && k < 12) begin cyc(); k++; end
    chk(nm, o_cmd_ready, 1'b1);
  endtask

  function automatic logic [2*PE-1:0] rnd_chunk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [17:0]     w[3];
  logic [2*PE-1:0] c[3];

  initial begin
    idle_in();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_cmd_ready", o_cmd_ready, 1'b1);
    chk("rst_error", o_error, 1'b0);
    chk("rst_score", o_score, 16'h0000);
    cyc();

    // LOAD_T of 20 bases: set_t, length, three words, then busy handshake.
    for (int k = 0; k < 3; k++) w[k] = 18'($urandom());
    i_t_word_valid = 1; i_t_word = w[0];
    cmd(2'b01, 16'd20, 16'd0);
    @(negedge clk); chk("d_set_t", o_set_t, 1'b1);
    cyc();
    @(negedge clk); chk("d_t_len", o_t, 18'd20); chk("d_set_t_once", o_set_t, 1'b0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      i_t_word = w[k];
      @(negedge clk); chk("d_t_word", o_t, w[k]); chk("d_t_ready", o_t_word_ready, 1'b1);
      cyc();
    end
    i_t_word_valid = 0; i_busy = 1;
    @(negedge clk); chk("d_t_wait_ready", o_t_word_ready, 1'b0);
    for (int k = 0; k < 5; k++) cyc();
    i_busy = 0;
    @(negedge clk); chk("d_t_wait_hold", o_cmd_ready, 1'b0);
    cyc();
    @(negedge clk); chk("d_t_wait_exit", o_cmd_ready, 1'b1);

    // RUN of 130 bases: 64, 64, 2, then an empty answer.
    for (int k = 0; k < 3; k++) c[k] = rnd_chunk();
    cmd(2'b10, 16'd0, 16'd130);
    hs_cnt = 0;
    i_s_chunk_valid = 1; i_s_chunk = c[0];
    @(negedge clk); chk("d_start_cal", o_start_cal, 1'b1);
    cyc();
    i_s_chunk = c[1]; i_request_s = 1;
    @(negedge clk); chk("d_start_once", o_start_cal, 1'b0);
    cyc();
    i_s_chunk = c[2];
    @(negedge clk); chk("d_s0", o_s, c[0]); chk("d_sv0", o_s_valid, 7'd64);
    cyc();
    i_s_chunk_valid = 0;
    @(negedge clk); chk("d_s1", o_s, c[1]); chk("d_sv1", o_s_valid, 7'd64);
    cyc();
    @(negedge clk); chk("d_s2", o_s, c[2]); chk("d_sv2", o_s_valid, 7'd2);
    cyc();
    i_request_s = 0;
    @(negedge clk); chk("d_s3", o_s, 128'd0); chk("d_sv3", o_s_valid, 7'd0);
    chk("d_no_err", o_error, 1'b0);
    cyc();
    chk("d_chunks", hs_cnt, 3);

    // Score return, then drain.
    i_valid = 1; i_result = 16'h002A;
    cyc();
    i_valid = 0;
    @(negedge clk); chk("d_score", o_score, 16'h002A); chk("d_done", o_done, 1'b1);
    cyc();
    @(negedge clk); chk("d_done_once", o_done, 1'b0); chk("d_drain", o_cmd_ready, 1'b0);
    wait_idle("d_drain_exit");

    // S underrun, CLEAR, zero-length LOAD_T.
    cmd(2'b10, 16'd0, 16'd10);
    i_request_s = 1;
    cyc();
    i_request_s = 0;
    @(negedge clk); chk("d_underrun", o_error, 1'b1); chk("d_err_ready", o_cmd_ready, 1'b0);
    cmd(2'b00, 16'd0, 16'd0);
    @(negedge clk); chk("d_clear_err", o_error, 1'b0); chk("d_clear_idle", o_cmd_ready, 1'b1);
    cmd(2'b01, 16'd0, 16'd0);
    @(negedge clk); chk("d_tlen0", o_error, 1'b1);
    cmd(2'b00, 16'd0, 16'd0);

    // RUN ignored in T_WAIT; T underrun mid-transfer.
    i_t_word_valid = 1; i_t_word = 18'h1FFFF;
    cmd(2'b01, 16'd9, 16'd0);
    cyc(); cyc(); cyc();
    i_t_word_valid = 0; i_busy = 1;
    i_cmd_valid = 1; i_cmd_op = 2'b10; i_s_len = 16'd50;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk); chk("d_run_ignored", o_start_cal, 1'b0);
    end
    i_cmd_valid = 0; i_busy = 0;
    wait_idle("d_twait_exit");
    i_t_word_valid = 1;
    cmd(2'b01, 16'd30, 16'd0);
    cyc(); cyc(); cyc();
    i_t_word_valid = 0;
    cyc();
    @(negedge clk); chk("d_t_underrun", o_error, 1'b1);
    cmd(2'b00, 16'd0, 16'd0);

    // Reset during CALC with an S chunk on the outputs.
    cmd(2'b10, 16'd0, 16'd100);
    i_request_s = 1; i_s_chunk_valid = 1; i_s_chunk = rnd_chunk();
    cyc();
    rst_n = 0;
    #1;
    chk("r_s", o_s, 128'd0); chk("r_sv", o_s_valid, 7'd0); chk("r_start", o_start_cal, 1'b0);
    chk("r_done", o_done, 1'b0); chk("r_err", o_error, 1'b0); chk("r_sready", o_s_chunk_ready, 1'b0);
    idle_in();
    cyc();
    rst_n = 1;
    @(negedge clk); chk("r_cmd_ready", o_cmd_ready, 1'b1); chk("r_no_pulse", o_done, 1'b0);
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      i_cmd_valid     = ($urandom_range(0, 7) == 0);
      i_cmd_op        = 2'($urandom_range(0, 3));
      i_t_len         = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      i_s_len         = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      i_t_word        = 18'($urandom());
      i_t_word_valid  = ($urandom_range(0, 19) != 0);
      i_s_chunk       = rnd_chunk();
      i_s_chunk_valid = ($urandom_range(0, 3) != 0);
      i_request_s     = ($urandom_range(0, 2) == 0);
      i_valid         = ($urandom_range(0, 39) == 0);
      i_result        = 16'($urandom());
      i_busy          = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0; cyc(); rst_n = 1;
      end
      cyc();
    end
    idle_in();
    cyc();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_host_driver.md
SW_HOST_DRIVER -- requirements
Module: sw_host_driver

Interface
REQ-001 SHALL have parameter PE_SIZE, default 64, bases per S chunk.
REQ-002 SHALL have parameter PE_SIZE_LOG, default 6, log2(PE_SIZE).
REQ-003 SHALL have parameter VEF_BIT, default 16, score width.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have host ports: i_cmd_valid in 1; i_cmd_op in 2 (00 CLEAR, 01 LOAD_T, 10 RUN, 11 ignored); i_t_len in 16 (T bases); i_s_len in 16 (S bases); o_cmd_ready out 1.
REQ-007 SHALL have T stream: i_t_word in 18 (9 bases, base k at [2k+1:2k]); i_t_word_valid in 1; o_t_word_ready out 1.
REQ-008 SHALL have S stream: i_s_chunk in 2*PE_SIZE (base k at [2k+1:2k]); i_s_chunk_valid in 1; o_s_chunk_ready out 1.
REQ-009 SHALL have accelerator ports: o_set_t out 1; o_start_cal out 1; o_t out 18; o_s out 2*PE_SIZE; o_s_valid out PE_SIZE_LOG+1; i_request_s in 1; i_busy in 1; i_result in VEF_BIT; i_valid in 1.
REQ-010 SHALL have status: o_done out 1 (pulse); o_score out VEF_BIT; o_error out 1 (sticky).

Function
REQ-011 SHALL implement states IDLE, T_ARM, T_LEN, T_DATA, T_WAIT, CALC, DRAIN, ERROR; o_cmd_ready=1 only in IDLE.
REQ-012 IDLE: command accepted on i_cmd_valid&o_cmd_ready; LOAD_T with i_t_len!=0 -> T_ARM; RUN with i_s_len!=0 -> CALC; LOAD_T/RUN with zero length -> ERROR; CLEAR/11 -> stay IDLE.
REQ-013 Commands arriving in non-IDLE states SHALL be ignored, except CLEAR in ERROR -> IDLE with o_error cleared.
REQ-014 T_ARM: wait until i_t_word_valid=1, then o_set_t=1 for exactly one cycle, -> T_LEN.
REQ-015 T_LEN: o_t = zero-extended latched t_len for one cycle, -> T_DATA; remaining-bases counter loaded with t_len.
REQ-016 T_DATA: each cycle o_t_word_ready=1, o_t=i_t_word, counter -= 9 saturating at 0; after the word that brings counter to 0, -> T_WAIT; ceil(t_len/9) words total, gapless.
REQ-017 T_DATA with i_t_word_valid=0 SHALL be underrun: o_t=0, -> ERROR.
REQ-018 T_WAIT and DRAIN: ignore i_busy for first 3 cycles (accelerator busy latency 2), then -> IDLE on first cycle i_busy=0.
REQ-019 CALC entry: o_start_cal=1 one cycle (cycle after RUN accept); S remaining counter loaded with s_len.
REQ-020 One-entry S buffer: o_s_chunk_ready=1 when buffer empty, or when buffer full and consumed same cycle, in CALC only.
REQ-021 i_request_s sampled high in CALC: next cycle o_s=chunk, o_s_valid=min(remaining,PE_SIZE), remaining -= o_s_valid; o_s/o_s_valid are 0 in all other cycles.
REQ-022 Request with empty buffer but i_s_chunk_valid=1 same cycle SHALL bypass buffer; with no chunk available and remaining!=0 -> ERROR (underrun).
REQ-023 Request with remaining=0 SHALL answer o_s=0, o_s_valid=0, no chunk consumed.
REQ-024 CALC: i_valid=1 -> o_score<=i_result, o_done=1 next cycle for one cycle, -> DRAIN; i_valid has priority over simultaneous i_request_s (request dropped).
REQ-025 ERROR: o_error=1, all accelerator outputs 0, both stream readies 0.
REQ-026 Undefined state encoding SHALL return to IDLE.

Reset
REQ-027 On rst_n=0: state IDLE, counters and S buffer cleared, o_score=0, o_error=0, o_done=0, o_set_t=0, o_start_cal=0, o_t=0, o_s=0, o_s_valid=0, stream readies 0; o_cmd_ready=1 after release.
REQ-028 Reset mid-operation SHALL discard all in-flight T/S data; no output pulse after release.

Verification
REQ-029 Reset during CALC -> all outputs at REQ-027 values next edge, o_cmd_ready=1 after release.
REQ-030 LOAD_T t_len=20, words valid -> o_set_t pulse, o_t=20, then 3 words consumed, T_WAIT; i_busy 1 for 5 cycles then 0 -> IDLE.
REQ-031 RUN s_len=130, PE_SIZE=64, 4 requests -> o_s_valid 64, 64, 2, 0; exactly 3 chunks consumed.
REQ-032 i_valid with i_result=16'h002A -> o_score=16'h002A, o_done one cycle, DRAIN then IDLE after i_busy=0.
REQ-033 Request with no chunk buffered/offered -> o_error=1, ERROR; CLEAR -> IDLE, o_error=0; LOAD_T t_len=0 -> ERROR.
REQ-034 RUN issued during T_WAIT -> ignored, o_start_cal stays 0; T_DATA valid dropped mid-transfer -> ERROR.
